// File: rtl/msg_arbiter_if.sv
// msg_arbiter_if: groups the per-channel request/read buses and the byte
// transmitter handshake of msg_arbiter into one bundle.
//   master : the arbiter side (drives read strobes and the tx byte stream)
//   slave  : the environment side (channels and host transmitter)
interface msg_arbiter_if #(
  parameter int N_CH = 5
);
  logic [N_CH-1:0]   have_msg_bus;
  logic [8*N_CH-1:0] len_bus;
  logic [8*N_CH-1:0] slave_data_bus;
  logic [N_CH-1:0]   rdreq_bus;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;

  modport master (
    input  have_msg_bus, len_bus, slave_data_bus, tx_ready,
    output rdreq_bus, tx_data, tx_valid, busy
  );

  modport slave (
    output have_msg_bus, len_bus, slave_data_bus, tx_ready,
    input  rdreq_bus, tx_data, tx_valid, busy
  );
endinterface

// File: rtl/msg_arbiter.sv
// msg_arbiter: round-robin arbiter that packs one channel's pending message
// into a byte packet SOP, ADDR, LEN, DATA... for a host transmitter. Data is
// pulled from per-channel non-show-ahead FIFOs (data valid one cycle after
// the read strobe).
// Optional feature: define MSG_CSUM_EN to append an XOR checksum byte over
// ADDR, LEN and the data bytes.
module msg_arbiter #(
  parameter int         N_CH = 5,
  parameter logic [7:0] SOP  = 8'hA5
) (
  input logic           sys_clk,
  input logic           rst,
  msg_arbiter_if.master bus
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

`ifdef MSG_CSUM_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, SOP_B = 3'd1, ADDR_B = 3'd2, LEN_B = 3'd3,
    FETCH = 3'd4, CAPT = 3'd5, DATA_B = 3'd6, CSUM_B = 3'd7
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, SOP_B = 3'd1, ADDR_B = 3'd2, LEN_B = 3'd3,
    FETCH = 3'd4, CAPT = 3'd5, DATA_B = 3'd6
  } state_e;
`endif

  state_e            state_q, state_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     last_grant_q, last_grant_d;
  logic [7:0]        cnt_q, cnt_d;          // latched length, then bytes left
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic [N_CH-1:0]   rdreq_q, rdreq_d;
`ifdef MSG_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic [N_CH-1:0]   eligible_s;
  logic              pick_found_s;
  logic [IW-1:0]     pick_idx_s;
  logic [7:0]        pick_len_s;
  logic [7:0]        sel_data_s;

  // Channel index at round-robin offset 'off' after 'base', modulo N_CH.
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
    int c;
    c = int'(base) + 1 + off;
    if (c >= N_CH) begin
      c = c - N_CH;
    end else begin
      c = c + 0;
    end
    return IW'(c);
  endfunction

  // Eligibility, round-robin pick and per-channel mux selects.
  always_comb begin
    eligible_s = '0;
    pick_idx_s = '0;
    pick_len_s = 8'h00;
    sel_data_s = 8'h00;
    for (int k = 0; k < N_CH; k++) begin
      eligible_s[k] = bus.have_msg_bus[k] & (bus.len_bus[8*k +: 8] != 8'h00);
    end
    // Walk offsets high to low so the nearest eligible channel wins last.
    for (int i = N_CH - 1; i >= 0; i--) begin
      pick_idx_s = eligible_s[rr_idx(last_grant_q, i)] ? rr_idx(last_grant_q, i) : pick_idx_s;
    end
    pick_found_s = |eligible_s;
    for (int k = 0; k < N_CH; k++) begin
      pick_len_s = pick_len_s | ({8{pick_idx_s == IW'(k)}} & bus.len_bus[8*k +: 8]);
      sel_data_s = sel_data_s | ({8{grant_q == IW'(k)}} & bus.slave_data_bus[8*k +: 8]);
    end
  end

  // Next-state, byte sequencing and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    tx_data_d    = tx_data_q;
`ifdef MSG_CSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          grant_d   = pick_idx_s;
          cnt_d     = pick_len_s;
          tx_data_d = SOP;
`ifdef MSG_CSUM_EN
          csum_d    = 8'(pick_idx_s) ^ pick_len_s;
`endif
          state_d   = SOP_B;
        end else begin
          state_d   = IDLE;
        end
      end
      SOP_B: begin
        if (bus.tx_ready) begin
          tx_data_d = 8'(grant_q);
          state_d   = ADDR_B;
        end else begin
          state_d   = SOP_B;
        end
      end
      ADDR_B: begin
        if (bus.tx_ready) begin
          tx_data_d = cnt_q;
          state_d   = LEN_B;
        end else begin
          state_d   = ADDR_B;
        end
      end
      LEN_B: begin
        if (bus.tx_ready) begin
          state_d = FETCH;
        end else begin
          state_d = LEN_B;
        end
      end
      FETCH: begin
        state_d = CAPT;
      end
      CAPT: begin
        tx_data_d = sel_data_s;
`ifdef MSG_CSUM_EN
        csum_d    = csum_q ^ sel_data_s;
`endif
        state_d   = DATA_B;
      end
      DATA_B: begin
        if (bus.tx_ready) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
`ifdef MSG_CSUM_EN
            tx_data_d    = csum_q;
            state_d      = CSUM_B;
`else
            last_grant_d = grant_q;
            state_d      = IDLE;
`endif
          end else begin
            state_d = FETCH;
          end
        end else begin
          state_d = DATA_B;
        end
      end
`ifdef MSG_CSUM_EN
      CSUM_B: begin
        if (bus.tx_ready) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else begin
          state_d      = CSUM_B;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    tx_valid_d = (state_d == SOP_B) || (state_d == ADDR_B) ||
                 (state_d == LEN_B) || (state_d == DATA_B);
`ifdef MSG_CSUM_EN
    tx_valid_d = tx_valid_d || (state_d == CSUM_B);
`endif
    busy_d           = (state_d != IDLE);
    rdreq_d          = '0;
    rdreq_d[grant_d] = (state_d == FETCH);
  end

  // State and output registers with synchronous reset (aborts any packet).
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(N_CH - 1);
      cnt_q        <= 8'h00;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      rdreq_q      <= '0;
`ifdef MSG_CSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
      rdreq_q      <= rdreq_d;
`ifdef MSG_CSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.busy      = busy_q;
  assign bus.rdreq_bus = rdreq_q;

endmodule

// File: tb/tb_msg_arbiter.sv
// tb_msg_arbiter: directed scenarios for msg_arbiter with a byte scoreboard.
// Stimulus pushes the expected packet bytes; a monitor pops and compares on
// every accepted tx byte and counts per-channel read strobes.
module tb_msg_arbiter;
  localparam int NC = 5;

  logic sys_clk;
  logic rst;

  msg_arbiter_if #(.N_CH(NC)) bus_if ();

  msg_arbiter #(.N_CH(NC), .SOP(8'hA5)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus_if.master)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int rd_cnt [NC] = '{default: 0};
  logic [7:0] mem [NC][64];
  logic [5:0] wr_ptr [NC] = '{default: 6'd0};
  logic [5:0] rd_ptr [NC] = '{default: 6'd0};

  // Channel FIFO model: data appears one cycle after the read strobe.
  always @(posedge sys_clk) begin
    for (int k = 0; k < NC; k++) begin
      if (bus_if.rdreq_bus[k]) begin
        bus_if.slave_data_bus[8*k +: 8] <= mem[k][rd_ptr[k]];
        rd_ptr[k] <= rd_ptr[k] + 6'd1;
      end
    end
  end

  // Monitor: strobe shape, strobe counts, and scoreboard on accepted bytes.
  always @(negedge sys_clk) begin
    logic [7:0] e;
    if (bus_if.rdreq_bus != '0) begin
      checks++;
      if ($countones(bus_if.rdreq_bus) != 1 || bus_if.tx_valid || !bus_if.busy) begin
        errors++;
        $display("FAIL rdreq_shape: rdreq=%b tx_valid=%b busy=%b, required one-hot, tx_valid=0, busy=1",
                 bus_if.rdreq_bus, bus_if.tx_valid, bus_if.busy);
      end
      for (int k = 0; k < NC; k++) begin
        if (bus_if.rdreq_bus[k]) rd_cnt[k]++;
      end
    end
    if (bus_if.tx_valid && bus_if.tx_ready) begin
      acc_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: got %h, no byte expected", bus_if.tx_data);
      end else begin
        e = exp_q.pop_front();
        if (bus_if.tx_data !== e) begin
          errors++;
          $display("FAIL tx_byte: got %h, expected %h", bus_if.tx_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic wait_busy(input logic v, input string name);
    int n;
    n = 0;
    while (bus_if.busy !== v && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    checks++;
    if (bus_if.busy !== v) begin
      errors++;
      $display("FAIL %s: busy=%b after timeout, expected %b", name, bus_if.busy, v);
    end
  endtask

  task automatic wait_acc(input int target, input string name);
    int n;
    n = 0;
    while (acc_cnt < target && n < 100) begin
      tick();
      n++;
    end
    check(name, int'(acc_cnt >= target), 1);
  endtask

  task automatic set_len(input int ch, input logic [7:0] v);
    bus_if.len_bus[8*ch +: 8] = v;
  endtask

  // Push the expected packet for channel ch and load its FIFO with the data.
  task automatic exp_pkt(input int ch, input int n, input logic [7:0] d0,
                         input logic [7:0] d1, input logic [7:0] d2);
    logic [7:0] d [3];
    logic [7:0] c;
    d[0] = d0; d[1] = d1; d[2] = d2;
    c = 8'(ch) ^ 8'(n);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(ch));
    exp_q.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(d[i]);
      c = c ^ d[i];
      mem[ch][wr_ptr[ch]] = d[i];
      wr_ptr[ch] = wr_ptr[ch] + 6'd1;
    end
`ifdef MSG_CSUM_EN
    exp_q.push_back(c);
`endif
  endtask

  initial begin
    int base, base_acc, bad, n;
    rst = 1'b1;
    bus_if.have_msg_bus = '0;
    bus_if.len_bus = '0;
    bus_if.tx_ready = 1'b0;
    repeat (3) tick();
    @(negedge sys_clk);
    check("rst_tx_valid", int'(bus_if.tx_valid), 0);
    check("rst_rdreq", int'(bus_if.rdreq_bus), 0);
    check("rst_tx_data", int'(bus_if.tx_data), 0);
    check("rst_busy", int'(bus_if.busy), 0);
    tick();
    rst = 1'b0;

    // Channel 4, three bytes, transmitter always ready.
    bus_if.tx_ready = 1'b1;
    set_len(4, 8'd3);
    exp_pkt(4, 3, 8'h11, 8'h22, 8'h33);
    base = rd_cnt[4];
    bus_if.have_msg_bus[4] = 1'b1;
    wait_busy(1'b1, "ch4_start");
    bus_if.have_msg_bus[4] = 1'b0;
    wait_busy(1'b0, "ch4_end");
    check("ch4_rdreq_count", rd_cnt[4] - base, 3);
    check("ch4_queue_empty", exp_q.size(), 0);

    // Round robin from reset: channel 1, then 3, then 1 again.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    set_len(1, 8'd1);
    set_len(3, 8'd1);
    exp_pkt(1, 1, 8'h5A, 8'h00, 8'h00);
    exp_pkt(3, 1, 8'hC3, 8'h00, 8'h00);
    exp_pkt(1, 1, 8'h5B, 8'h00, 8'h00);
    bus_if.have_msg_bus[1] = 1'b1;
    bus_if.have_msg_bus[3] = 1'b1;
    wait_busy(1'b1, "rr_p1_start");
    wait_busy(1'b0, "rr_p1_end");
    wait_busy(1'b1, "rr_p2_start");
    wait_busy(1'b0, "rr_p2_end");
    wait_busy(1'b1, "rr_p3_start");
    bus_if.have_msg_bus = '0;
    wait_busy(1'b0, "rr_p3_end");
    check("rr_queue_empty", exp_q.size(), 0);

    // Zero length on channel 2 is never granted.
    set_len(2, 8'd0);
    bus_if.have_msg_bus[2] = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (bus_if.busy || bus_if.rdreq_bus != '0) bad++;
    end
    check("len0_no_grant", bad, 0);
    bus_if.have_msg_bus[2] = 1'b0;

    // Transmitter stall of 10 cycles on the second data byte.
    set_len(0, 8'd3);
    base = rd_cnt[0];
    base_acc = acc_cnt;
    exp_pkt(0, 3, 8'h10, 8'h20, 8'h30);
    bus_if.have_msg_bus[0] = 1'b1;
    wait_busy(1'b1, "stall_start");
    bus_if.have_msg_bus[0] = 1'b0;
    wait_acc(base_acc + 4, "stall_reach_d1");
    bus_if.tx_ready = 1'b0;
    n = 0;
    while (!bus_if.tx_valid && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    bad = 0;
    repeat (10) begin
      if (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== 8'h20 || bus_if.rdreq_bus != '0) bad++;
      @(negedge sys_clk);
    end
    check("stall_stable", bad, 0);
    check("stall_rdreq_count", rd_cnt[0] - base, 2);
    bus_if.tx_ready = 1'b1;
    wait_busy(1'b0, "stall_end");
    check("stall_total_rdreq", rd_cnt[0] - base, 3);
    check("stall_queue_empty", exp_q.size(), 0);

    // Reset while the LEN byte is waiting; the packet restarts from SOP.
    set_len(0, 8'd2);
    base = rd_cnt[0];
    base_acc = acc_cnt;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h00);
    bus_if.have_msg_bus[0] = 1'b1;
    wait_acc(base_acc + 2, "rst_reach_len");
    bus_if.tx_ready = 1'b0;
    rst = 1'b1;
    tick();
    @(negedge sys_clk);
    check("midrst_tx_valid", int'(bus_if.tx_valid), 0);
    check("midrst_rdreq", int'(bus_if.rdreq_bus), 0);
    check("midrst_busy", int'(bus_if.busy), 0);
    check("midrst_queue", exp_q.size(), 0);
    exp_pkt(0, 2, 8'h77, 8'h88, 8'h00);
    rst = 1'b0;
    bus_if.tx_ready = 1'b1;
    wait_busy(1'b1, "regrant_start");
    bus_if.have_msg_bus[0] = 1'b0;
    wait_busy(1'b0, "regrant_end");
    check("regrant_rdreq_count", rd_cnt[0] - base, 2);
    check("regrant_queue_empty", exp_q.size(), 0);

    // Length changes after grant do not affect the packet.
    set_len(3, 8'd2);
    base = rd_cnt[3];
    exp_pkt(3, 2, 8'hE1, 8'hE2, 8'h00);
    bus_if.have_msg_bus[3] = 1'b1;
    wait_busy(1'b1, "lenchg_start");
    set_len(3, 8'd7);
    bus_if.have_msg_bus[3] = 1'b0;
    wait_busy(1'b0, "lenchg_end");
    check("lenchg_rdreq_count", rd_cnt[3] - base, 2);
    repeat (5) tick();
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
